// File: rtl/rv32_pkg.sv
// Shared RV32 pipeline constants and payload types used by the stage-control slice.
package rv32_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [INSTR_W-1:0]  RV32_NOP      = 32'h0000_0013;
  localparam logic [XLEN_DEF-1:0] RV32_RESET_PC = 32'h0000_0000;

  typedef logic [REG_ADDR_W-1:0] regAddr_t;

  // Control payload carried by the DE/EX register.
  typedef struct packed {
    regAddr_t rd_addr;
    logic     rd_we;
    logic     mem_we;
    logic     valid;
  } de_ex_t;

  localparam de_ex_t DE_EX_BUBBLE = '{rd_addr: '0, rd_we: 1'b0, mem_we: 1'b0, valid: 1'b0};

endpackage

// File: rtl/pipeline_stage_ctrl_stall_watchdog.sv
// Consecutive-stall counter with a sticky flag raised when the count saturates.
module stall_watchdog #(
  parameter int unsigned STALL_CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stall,
  input  logic clear,
  output logic fired
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  logic [STALL_CNT_W-1:0] cnt_q;
  logic [STALL_CNT_W-1:0] cnt_d;
  logic                   fired_d;

  // Count only uninterrupted stalls; a redirect or a free cycle restarts the run.
  always_comb begin
    cnt_d   = '0;
    fired_d = fired;
    if (stall && !clear) begin
      cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + STALL_CNT_W'(1);
    end
    if (cnt_d == CNT_MAX) begin
      fired_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      fired <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      fired <= fired_d;
    end
  end

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// IF/DE and DE/EX register control: applies hazard-unit stalls/flushes and branch squashes,
// owns the stage valid bits and the stall watchdog.
module pipeline_stage_ctrl
  import rv32_pkg::*;
#(
  parameter int unsigned            XLEN        = 32,
  parameter logic [XLEN-1:0]        RESET_PC    = XLEN'(RV32_RESET_PC),
  parameter logic [INSTR_W-1:0]     NOP_INSTR   = RV32_NOP,
  parameter int unsigned            STALL_CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stallIFDE,
  input  logic               flushEX,
  input  logic               branchTakenEX,
  input  logic [INSTR_W-1:0] instrIF,
  input  logic [XLEN-1:0]    pcIF,
  input  logic               validIF,
  input  regAddr_t           rdAddrDE,
  input  logic               rdWriteEnDE,
  input  logic               memWriteEnDE,
  output logic               pcEnIF,
  output logic [INSTR_W-1:0] instrDE,
  output logic [XLEN-1:0]    pcDE,
  output logic               validDE,
  output regAddr_t           rdAddrEX,
  output logic               rdWriteEnEX,
  output logic               memWriteEnEX,
  output logic               validEX,
  output logic               stallWatchdog
);

  de_ex_t de_ex_q;
  de_ex_t de_ex_d;
  logic   bubble_ex;

  // A redirect must always advance fetch, even when the hazard unit asks for a hold.
  assign pcEnIF = ~stallIFDE | branchTakenEX;

  // IF/DE: squash beats hold beats load; pcDE is left alone on a squash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrDE <= NOP_INSTR;
      pcDE    <= RESET_PC;
      validDE <= 1'b0;
    end else if (branchTakenEX) begin
      instrDE <= NOP_INSTR;
      validDE <= 1'b0;
    end else if (!stallIFDE) begin
      instrDE <= instrIF;
      pcDE    <= pcIF;
      validDE <= validIF;
    end
  end

  // DE/EX: bubble on squash, flush or an empty decode slot; stall alone does not bubble.
  assign bubble_ex = branchTakenEX | flushEX | ~validDE;

  always_comb begin
    de_ex_d = DE_EX_BUBBLE;
    if (!bubble_ex) begin
      de_ex_d.rd_addr = rdAddrDE;
      de_ex_d.rd_we   = rdWriteEnDE;
      de_ex_d.mem_we  = memWriteEnDE;
      de_ex_d.valid   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_ex_q <= DE_EX_BUBBLE;
    end else begin
      de_ex_q <= de_ex_d;
    end
  end

  assign rdAddrEX     = de_ex_q.rd_addr;
  assign rdWriteEnEX  = de_ex_q.rd_we;
  assign memWriteEnEX = de_ex_q.mem_we;
  assign validEX      = de_ex_q.valid;

  stall_watchdog #(
    .STALL_CNT_W (STALL_CNT_W)
  ) u_stall_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .stall (stallIFDE),
    .clear (branchTakenEX),
    .fired (stallWatchdog)
  );

endmodule
